sync_frame_tx_1101: RTL and testbench

- Serial frame transmitter: the transmit end of the 1101 sync-word link.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits one bit per clock on a single serial line: 4-bit sync word, then payload MSB-first, then an optional even-parity bit.
- Idle line level is 0. Downstream 1101 Moore detectors use the sync word to find frame starts.

---
 rtl/sync_frame_tx_1101.sv | 150 +++++++++++++++
 tb/tb_sync_frame_tx_1101.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx_1101.sv
// Serial frame transmitter: sync word, MSB-first payload, optional even parity.
// Accepts a payload over valid/ready and can run frames back to back with no idle gap.
module sync_frame_tx_1101 #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1,
  parameter logic [3:0]  SYNC_PAT  = 4'b1101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              frame_active,
  output logic              done
);

  localparam int unsigned CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_PAR  = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_dout;
  logic              r_active;
  logic              r_done;

  logic [1:0]        w_state;
  logic [CNT_W-1:0]  w_cnt;
  logic [DATA_W-1:0] w_shift;
  logic              w_par;
  logic              w_dout;
  logic              w_active;
  logic              w_done;
  logic              w_last;
  logic              w_ready;
  logic              w_accept;
  logic [1:0]        w_sync_idx;

  // Final bit of the current frame is on the line this cycle.
  assign w_last   = (r_state == S_PAR) ||
                    ((r_state == S_DATA) && (r_cnt == DATA_LAST) && !HAS_PAR);
  assign w_ready  = (r_state == S_IDLE) || w_last;
  assign w_accept = in_valid && w_ready;
  assign in_ready = w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_dout   <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_shift  <= w_shift;
      r_par    <= w_par;
      r_dout   <= w_dout;
      r_active <= w_active;
      r_done   <= w_done;
    end
  end

  // Next state; an accept overrides whatever the final-bit cycle would do.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_par   = r_par;
    if (w_accept) begin
      w_state = S_SYNC;
      w_cnt   = '0;
      w_shift = in_data;
      w_par   = ^in_data;
    end else begin
      case (r_state)
        S_SYNC: begin
          if (r_cnt == SYNC_LAST) begin
            w_state = S_DATA;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == DATA_LAST) begin
            w_state = HAS_PAR ? S_PAR : S_IDLE;
            w_cnt   = '0;
          end else begin
            w_cnt   = r_cnt + CNT_W'(1);
            w_shift = r_shift << 1;
          end
        end
        S_PAR: begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      endcase
    end
  end

  // Moore outputs derived from the next state so they register alongside it.
  always_comb begin
    w_dout     = 1'b0;
    w_active   = 1'b0;
    w_sync_idx = 2'(2'd3 - w_cnt[1:0]);
    case (w_state)
      S_SYNC: begin
        w_dout   = SYNC_PAT[w_sync_idx];
        w_active = 1'b1;
      end
      S_DATA: begin
        w_dout   = w_shift[DATA_W-1];
        w_active = 1'b1;
      end
      S_PAR: begin
        w_dout   = w_par;
        w_active = 1'b1;
      end
      default: begin
        w_dout   = 1'b0;
        w_active = 1'b0;
      end
    endcase
    w_done = (w_state == S_PAR) ||
             ((w_state == S_DATA) && (w_cnt == DATA_LAST) && !HAS_PAR);
  end

  assign dout         = r_dout;
  assign frame_active = r_active;
  assign done         = r_done;

endmodule

// File: tb/tb_sync_frame_tx_1101.sv
// Bench for sync_frame_tx_1101: a parity and a no-parity instance share stimulus,
// each checked every cycle against a frame-queue reference model.
module tb_sync_frame_tx_1101;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       rdy_p, dout_p, act_p, done_p;
  logic       rdy_n, dout_n, act_n, done_n;

  int n_tests = 0;
  int n_fail  = 0;

  sync_frame_tx_1101 #(.DATA_W(8), .PARITY_EN(1), .SYNC_PAT(4'b1101)) u_dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_p), .dout(dout_p), .frame_active(act_p), .done(done_p)
  );

  sync_frame_tx_1101 #(.DATA_W(8), .PARITY_EN(0), .SYNC_PAT(4'b1101)) u_dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_n), .dout(dout_n), .frame_active(act_n), .done(done_n)
  );

  always #5 clk = ~clk;

  // Model: the frame is a bit string; m_rem counts bits still to be sent (current one included).
  logic [15:0] m_bits [2];
  int          m_rem  [2];

  function automatic logic [15:0] frame_of(logic [7:0] d, bit par);
    if (par) return {3'b000, 4'b1101, d, ^d};
    return {4'b0000, 4'b1101, d};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit ready = (m_rem[k] <= 1);
      if (rst) m_rem[k] = 0;
      else if (in_valid && ready) begin
        m_bits[k] = frame_of(in_data, k == 0);
        m_rem[k]  = (k == 0) ? 13 : 12;
      end else if (m_rem[k] > 0) m_rem[k]--;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ix = 4'(m_rem[k] - 1);
      logic e_dout = (m_rem[k] > 0) ? m_bits[k][ix] : 1'b0;
      logic e_act  = (m_rem[k] > 0);
      logic e_done = (m_rem[k] == 1);
      logic e_rdy  = (m_rem[k] <= 1);
      if (k == 0) begin
        chk("p.dout", 32'(dout_p), 32'(e_dout));
        chk("p.frame_active", 32'(act_p), 32'(e_act));
        chk("p.done", 32'(done_p), 32'(e_done));
        chk("p.in_ready", 32'(rdy_p), 32'(e_rdy));
      end else begin
        chk("n.dout", 32'(dout_n), 32'(e_dout));
        chk("n.frame_active", 32'(act_n), 32'(e_act));
        chk("n.done", 32'(done_n), 32'(e_done));
        chk("n.in_ready", 32'(rdy_n), 32'(e_rdy));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit         rst;
    bit         valid;
    logic [7:0] data;
    bit         dout;
    bit         act;
    bit         done;
    bit         rdy;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [12:0] a5_bits;
    logic [12:0] got;
    int          run;
    int          acc_at;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    m_rem[0] = 0;
    m_rem[1] = 0;
    m_bits[0] = '0;
    m_bits[1] = '0;

    // Literal table for the 0xA5 parity frame: 1101 10100101 0.
    a5_bits = 13'b1101_10100101_0;
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 2; i <= 13; i++)
      tbl[i] = '{1'b0, 1'b0, 8'h00, a5_bits[13-i], 1'b1, (i == 13), (i == 13)};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst      = tbl[i].rst;
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      step();
      chk($sformatf("tbl[%0d].dout", i), 32'(dout_p), 32'(tbl[i].dout));
      chk($sformatf("tbl[%0d].act", i), 32'(act_p), 32'(tbl[i].act));
      chk($sformatf("tbl[%0d].done", i), 32'(done_p), 32'(tbl[i].done));
      chk($sformatf("tbl[%0d].rdy", i), 32'(rdy_p), 32'(tbl[i].rdy));
    end
    idle(4);

    // Reset then 10 idle cycles.
    rst = 1'b1;
    step();
    idle(10);

    // Back-to-back 0xFF then 0x01 with in_valid held high.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_data = 8'h01;
    run     = act_p ? 1 : 0;
    acc_at  = -1;
    for (int c = 1; c < 40; c++) begin
      if ((m_rem[0] <= 1) && in_valid) acc_at = c;
      step();
      if (acc_at == c) in_valid = 1'b0;
      if (act_p) run++;
      else break;
    end
    chk("b2b.second_accept_cycle", 32'(acc_at), 32'd13);
    chk("b2b.active_run", 32'(run), 32'd26);
    idle(16);

    // No-parity instance: 0x3C gives 1101 00111100, done on bit 12.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      got = {got[11:0], dout_n};
      if (i == 11) chk("np.done_last", 32'(done_n), 32'd1);
      if (i < 11) step();
    end
    chk("np.frame_3c", 32'(got[11:0]), 32'h D3C);
    idle(16);

    // Reset mid-frame during the payload, then a clean 0x5A frame.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.dout", 32'(dout_p), 32'd0);
    chk("rst_mid.act", 32'(act_p), 32'd0);
    chk("rst_mid.rdy", 32'(rdy_p), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    got = '0;
    for (int i = 0; i < 13; i++) begin
      got = {got[11:0], dout_p};
      if (i < 12) step();
    end
    chk("rst_mid.frame_5a", 32'(got), 32'(13'b1101_01011010_0));
    idle(16);

    // in_data churning every cycle with in_valid high.
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'($urandom);
      step();
    end
    idle(16);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      step();
    end
    idle(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
